// File: rtl/dfx_axil_decoupler.sv
// dfx_axil_decoupler: AXI4-Lite isolation stage in front of a DFX reconfigurable partition.
// Traffic is answered locally with SLVERR while decoupled or after an RP timeout.
module dfx_axil_decoupler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        AxiBusClock,
    input  logic        xAxiBusReset_n,
    input  logic        decouple,
    input  logic        clear_timeout,
    output logic        decouple_status,
    output logic        rp_timeout,
    input  logic [31:0] sPcie_AXI_awaddr,
    input  logic [2:0]  sPcie_AXI_awprot,
    input  logic        sPcie_AXI_awvalid,
    output logic        sPcie_AXI_awready,
    input  logic [31:0] sPcie_AXI_wdata,
    input  logic [3:0]  sPcie_AXI_wstrb,
    input  logic        sPcie_AXI_wvalid,
    output logic        sPcie_AXI_wready,
    output logic [1:0]  sPcie_AXI_bresp,
    output logic        sPcie_AXI_bvalid,
    input  logic        sPcie_AXI_bready,
    input  logic [31:0] sPcie_AXI_araddr,
    input  logic [2:0]  sPcie_AXI_arprot,
    input  logic        sPcie_AXI_arvalid,
    output logic        sPcie_AXI_arready,
    output logic [31:0] sPcie_AXI_rdata,
    output logic [1:0]  sPcie_AXI_rresp,
    output logic        sPcie_AXI_rvalid,
    input  logic        sPcie_AXI_rready,
    output logic [31:0] mRp_AXI_awaddr,
    output logic [2:0]  mRp_AXI_awprot,
    output logic        mRp_AXI_awvalid,
    input  logic        mRp_AXI_awready,
    output logic [31:0] mRp_AXI_wdata,
    output logic [3:0]  mRp_AXI_wstrb,
    output logic        mRp_AXI_wvalid,
    input  logic        mRp_AXI_wready,
    input  logic [1:0]  mRp_AXI_bresp,
    input  logic        mRp_AXI_bvalid,
    output logic        mRp_AXI_bready,
    output logic [31:0] mRp_AXI_araddr,
    output logic [2:0]  mRp_AXI_arprot,
    output logic        mRp_AXI_arvalid,
    input  logic        mRp_AXI_arready,
    input  logic [31:0] mRp_AXI_rdata,
    input  logic [1:0]  mRp_AXI_rresp,
    input  logic        mRp_AXI_rvalid,
    output logic        mRp_AXI_rready
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;

    wr_state_t r_wst;
    rd_state_t r_rst;
    logic          r_rst_done, r_rp_timeout, r_dec_status;
    logic          r_aw_full, r_w_full, r_ar_full;
    logic [31:0]   r_awaddr, r_wdata, r_araddr, r_rdata;
    logic [2:0]    r_awprot, r_arprot;
    logic [3:0]    r_wstrb;
    logic          r_m_awvalid, r_m_wvalid, r_m_arvalid;
    logic [1:0]    r_bresp, r_rresp;
    logic [CW-1:0] r_wcnt, r_rcnt;

    logic w_dec_eff, w_to_nxt;
    logic w_aw_hs, w_w_hs, w_wr_both, w_wr_busy, w_wr_ack, w_wr_to, w_wr_busy_nxt;
    logic w_ar_hs, w_rd_both, w_rd_busy, w_rd_ack, w_rd_to, w_rd_busy_nxt;

    assign w_dec_eff = decouple | r_rp_timeout;

    assign w_aw_hs       = sPcie_AXI_awvalid & sPcie_AXI_awready;
    assign w_w_hs        = sPcie_AXI_wvalid & sPcie_AXI_wready;
    assign w_wr_both     = (r_wst == W_IDLE) & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    assign w_wr_busy     = (r_wst == W_ISSUE) | (r_wst == W_WAIT);
    assign w_wr_ack      = (r_wst == W_WAIT) & mRp_AXI_bvalid;
    assign w_wr_to       = w_wr_busy & (r_wcnt == CNT_MAX) & ~w_wr_ack;
    assign w_wr_busy_nxt = (w_wr_both & ~w_dec_eff) | (w_wr_busy & ~w_wr_ack & ~w_wr_to);

    assign w_ar_hs       = sPcie_AXI_arvalid & sPcie_AXI_arready;
    assign w_rd_both     = (r_rst == R_IDLE) & (r_ar_full | w_ar_hs);
    assign w_rd_busy     = (r_rst == R_ISSUE) | (r_rst == R_WAIT);
    assign w_rd_ack      = (r_rst == R_WAIT) & mRp_AXI_rvalid;
    assign w_rd_to       = w_rd_busy & (r_rcnt == CNT_MAX) & ~w_rd_ack;
    assign w_rd_busy_nxt = (w_rd_both & ~w_dec_eff) | (w_rd_busy & ~w_rd_ack & ~w_rd_to);

    // A new timeout wins over a same-cycle clear.
    assign w_to_nxt = w_wr_to | w_rd_to | (r_rp_timeout & ~clear_timeout);

    assign sPcie_AXI_awready = r_rst_done & (r_wst == W_IDLE) & ~r_aw_full;
    assign sPcie_AXI_wready  = r_rst_done & (r_wst == W_IDLE) & ~r_w_full;
    assign sPcie_AXI_bvalid  = (r_wst == W_RESP);
    assign sPcie_AXI_bresp   = r_bresp;
    assign sPcie_AXI_arready = r_rst_done & (r_rst == R_IDLE) & ~r_ar_full;
    assign sPcie_AXI_rvalid  = (r_rst == R_RESP);
    assign sPcie_AXI_rdata   = r_rdata;
    assign sPcie_AXI_rresp   = r_rresp;

    assign mRp_AXI_awaddr  = r_awaddr;
    assign mRp_AXI_awprot  = r_awprot;
    assign mRp_AXI_awvalid = r_m_awvalid;
    assign mRp_AXI_wdata   = r_wdata;
    assign mRp_AXI_wstrb   = r_wstrb;
    assign mRp_AXI_wvalid  = r_m_wvalid;
    assign mRp_AXI_araddr  = r_araddr;
    assign mRp_AXI_arprot  = r_arprot;
    assign mRp_AXI_arvalid = r_m_arvalid;
    // After a fault, stale RP responses are drained and dropped.
    assign mRp_AXI_bready  = (r_wst == W_WAIT) | r_rp_timeout;
    assign mRp_AXI_rready  = (r_rst == R_WAIT) | r_rp_timeout;

    assign decouple_status = r_dec_status;
    assign rp_timeout      = r_rp_timeout;

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            r_rst_done   <= 1'b0;
            r_rp_timeout <= 1'b0;
            r_dec_status <= 1'b0;
        end else begin
            r_rst_done   <= 1'b1;
            r_rp_timeout <= w_to_nxt;
            r_dec_status <= (decouple | w_to_nxt) & ~w_wr_busy_nxt & ~w_rd_busy_nxt;
        end
    end

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            r_wst       <= W_IDLE;
            r_aw_full   <= 1'b0;
            r_w_full    <= 1'b0;
            r_awaddr    <= '0;
            r_awprot    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_bresp     <= '0;
            r_wcnt      <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= sPcie_AXI_awaddr;
                r_awprot  <= sPcie_AXI_awprot;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= sPcie_AXI_wdata;
                r_wstrb  <= sPcie_AXI_wstrb;
            end
            case (r_wst)
                W_IDLE: begin
                    if (w_wr_both && w_dec_eff) begin
                        r_bresp <= 2'b10;
                        r_wst   <= W_RESP;
                    end else if (w_wr_both) begin
                        r_m_awvalid <= 1'b1;
                        r_m_wvalid  <= 1'b1;
                        r_wcnt      <= '0;
                        r_wst       <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    r_wcnt      <= r_wcnt + 1'b1;
                    r_m_awvalid <= r_m_awvalid & ~mRp_AXI_awready;
                    r_m_wvalid  <= r_m_wvalid & ~mRp_AXI_wready;
                    if ((~r_m_awvalid | mRp_AXI_awready) && (~r_m_wvalid | mRp_AXI_wready))
                        r_wst <= W_WAIT;
                end
                W_WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (mRp_AXI_bvalid) begin
                        r_bresp <= mRp_AXI_bresp;
                        r_wst   <= W_RESP;
                    end
                end
                default: begin
                    if (sPcie_AXI_bready) begin
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                        r_wst     <= W_IDLE;
                    end
                end
            endcase
            if (w_wr_to) begin
                r_m_awvalid <= 1'b0;
                r_m_wvalid  <= 1'b0;
                r_bresp     <= 2'b10;
                r_wst       <= W_RESP;
            end
        end
    end

    always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
        if (!xAxiBusReset_n) begin
            r_rst       <= R_IDLE;
            r_ar_full   <= 1'b0;
            r_araddr    <= '0;
            r_arprot    <= '0;
            r_m_arvalid <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= '0;
            r_rcnt      <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ar_full <= 1'b1;
                r_araddr  <= sPcie_AXI_araddr;
                r_arprot  <= sPcie_AXI_arprot;
            end
            case (r_rst)
                R_IDLE: begin
                    if (w_rd_both && w_dec_eff) begin
                        r_rdata <= ERR_RDATA;
                        r_rresp <= 2'b10;
                        r_rst   <= R_RESP;
                    end else if (w_rd_both) begin
                        r_m_arvalid <= 1'b1;
                        r_rcnt      <= '0;
                        r_rst       <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    r_rcnt      <= r_rcnt + 1'b1;
                    r_m_arvalid <= r_m_arvalid & ~mRp_AXI_arready;
                    if (~r_m_arvalid | mRp_AXI_arready)
                        r_rst <= R_WAIT;
                end
                R_WAIT: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (mRp_AXI_rvalid) begin
                        r_rdata <= mRp_AXI_rdata;
                        r_rresp <= mRp_AXI_rresp;
                        r_rst   <= R_RESP;
                    end
                end
                default: begin
                    if (sPcie_AXI_rready) begin
                        r_ar_full <= 1'b0;
                        r_rst     <= R_IDLE;
                    end
                end
            endcase
            if (w_rd_to) begin
                r_m_arvalid <= 1'b0;
                r_rdata     <= ERR_RDATA;
                r_rresp     <= 2'b10;
                r_rst       <= R_RESP;
            end
        end
    end
endmodule

// File: tb/tb_dfx_axil_decoupler.sv
// tb_dfx_axil_decoupler: directed bench with response scoreboards for the AXI-Lite decoupler.
module tb_dfx_axil_decoupler;
    localparam int TO = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic decouple = 1'b0, clear_timeout = 1'b0;
    logic dec_status, rp_to;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
    logic [2:0]  s_awprot = '0, s_arprot = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0, s_bready = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata = '0;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0, m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;

    int checks = 0, errors = 0, ar_seen = 0;
    logic [1:0]  wq[$];
    logic [33:0] rq[$];

    dfx_axil_decoupler #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
        .AxiBusClock(clk), .xAxiBusReset_n(rst_n), .decouple(decouple), .clear_timeout(clear_timeout),
        .decouple_status(dec_status), .rp_timeout(rp_to),
        .sPcie_AXI_awaddr(s_awaddr), .sPcie_AXI_awprot(s_awprot), .sPcie_AXI_awvalid(s_awvalid), .sPcie_AXI_awready(s_awready),
        .sPcie_AXI_wdata(s_wdata), .sPcie_AXI_wstrb(s_wstrb), .sPcie_AXI_wvalid(s_wvalid), .sPcie_AXI_wready(s_wready),
        .sPcie_AXI_bresp(s_bresp), .sPcie_AXI_bvalid(s_bvalid), .sPcie_AXI_bready(s_bready),
        .sPcie_AXI_araddr(s_araddr), .sPcie_AXI_arprot(s_arprot), .sPcie_AXI_arvalid(s_arvalid), .sPcie_AXI_arready(s_arready),
        .sPcie_AXI_rdata(s_rdata), .sPcie_AXI_rresp(s_rresp), .sPcie_AXI_rvalid(s_rvalid), .sPcie_AXI_rready(s_rready),
        .mRp_AXI_awaddr(m_awaddr), .mRp_AXI_awprot(m_awprot), .mRp_AXI_awvalid(m_awvalid), .mRp_AXI_awready(m_awready),
        .mRp_AXI_wdata(m_wdata), .mRp_AXI_wstrb(m_wstrb), .mRp_AXI_wvalid(m_wvalid), .mRp_AXI_wready(m_wready),
        .mRp_AXI_bresp(m_bresp), .mRp_AXI_bvalid(m_bvalid), .mRp_AXI_bready(m_bready),
        .mRp_AXI_araddr(m_araddr), .mRp_AXI_arprot(m_arprot), .mRp_AXI_arvalid(m_arvalid), .mRp_AXI_arready(m_arready),
        .mRp_AXI_rdata(m_rdata), .mRp_AXI_rresp(m_rresp), .mRp_AXI_rvalid(m_rvalid), .mRp_AXI_rready(m_rready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_arvalid) ar_seen <= ar_seen + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic s_aw(input logic [31:0] a);
        s_awaddr = a; s_awprot = 3'd2; s_awvalid = 1'b1;
        for (int i = 0; i < 50 && !s_awready; i++) @(negedge clk);
        chk("aw_ready", s_awready, 1);
        @(negedge clk);
        s_awvalid = 1'b0;
    endtask

    task automatic s_w(input logic [31:0] d, input logic [3:0] s);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        for (int i = 0; i < 50 && !s_wready; i++) @(negedge clk);
        chk("w_ready", s_wready, 1);
        @(negedge clk);
        s_wvalid = 1'b0;
    endtask

    task automatic s_ar(input logic [31:0] a);
        s_araddr = a; s_arprot = 3'd5; s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !s_arready; i++) @(negedge clk);
        chk("ar_ready", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
    endtask

    task automatic s_b();
        logic [1:0] e;
        for (int i = 0; i < 50 && !s_bvalid; i++) @(negedge clk);
        chk("b_valid", s_bvalid, 1);
        if (wq.size() != 0) e = wq.pop_front(); else e = 'x;
        chk("b_resp", s_bresp, e);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic s_r();
        logic [33:0] e;
        for (int i = 0; i < 50 && !s_rvalid; i++) @(negedge clk);
        chk("r_valid", s_rvalid, 1);
        if (rq.size() != 0) e = rq.pop_front(); else e = 'x;
        chk("r_data", s_rdata, e[31:0]);
        chk("r_resp", s_rresp, e[33:32]);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic rp_write(input int dly, input logic [1:0] resp, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 50 && !(m_awvalid && m_wvalid); i++) @(negedge clk);
        chk("rp_awvalid", m_awvalid, 1);
        chk("rp_wvalid", m_wvalid, 1);
        chk("rp_awaddr", m_awaddr, a);
        chk("rp_awprot", m_awprot, 3'd2);
        chk("rp_wdata", m_wdata, d);
        chk("rp_wstrb", m_wstrb, s);
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0;
        repeat (dly) @(negedge clk);
        chk("rp_bready", m_bready, 1);
        chk("b_early", s_bvalid, 0);
        m_bresp = resp; m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0;
        chk("b_fwd_lat", s_bvalid, 1);
    endtask

    task automatic rp_read(input int dly, input logic [31:0] d, input logic [1:0] resp, input logic [31:0] a);
        m_arready = 1'b1;
        for (int i = 0; i < 50 && !m_arvalid; i++) @(negedge clk);
        chk("rp_arvalid", m_arvalid, 1);
        chk("rp_araddr", m_araddr, a);
        chk("rp_arprot", m_arprot, 3'd5);
        @(negedge clk);
        m_arready = 1'b0;
        repeat (dly) @(negedge clk);
        chk("rp_rready", m_rready, 1);
        chk("r_early", s_rvalid, 0);
        m_rdata = d; m_rresp = resp; m_rvalid = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b0;
        chk("r_fwd_lat", s_rvalid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int ar0, n;
        repeat (3) @(negedge clk);
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        chk("rst_rp_timeout", rp_to, 0);
        chk("rst_dec_status", dec_status, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", s_awready, 1);

        // normal write, RP answers OKAY after 3 cycles
        wq.push_back(2'b00);
        fork
            s_aw(32'h0000_0010);
            s_w(32'hA5A5_5A5A, 4'hF);
            rp_write(3, 2'b00, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
        join
        s_b();

        // decoupled read and write answered locally
        decouple = 1'b1;
        ar0 = ar_seen;
        @(negedge clk);
        rq.push_back({2'b10, 32'hDEADBEEF});
        s_ar(32'h4);
        chk("dec_rd_lat", s_rvalid, 1);
        chk("dec_status", dec_status, 1);
        s_r();
        wq.push_back(2'b10);
        s_w(32'h1, 4'h3);
        chk("dec_wr_wait_aw", s_bvalid, 0);
        s_aw(32'h8);
        chk("dec_wr_lat", s_bvalid, 1);
        s_b();
        chk("dec_no_arvalid", ar_seen - ar0, 0);
        decouple = 1'b0;

        // decouple raised while a read is outstanding
        rq.push_back({2'b00, 32'h1234_5678});
        m_arready = 1'b1;
        s_ar(32'hC);
        chk("mf_arvalid", m_arvalid, 1);
        chk("mf_araddr", m_araddr, 32'hC);
        @(negedge clk);
        m_arready = 1'b0;
        chk("mf_ar_drop", m_arvalid, 0);
        @(negedge clk);
        decouple = 1'b1;
        repeat (3) @(negedge clk);
        chk("mf_status_busy", dec_status, 0);
        chk("mf_rready", m_rready, 1);
        m_rdata = 32'h1234_5678; m_rresp = 2'b00; m_rvalid = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b0;
        chk("mf_r_fwd", s_rvalid, 1);
        chk("mf_status_done", dec_status, 1);
        s_r();
        decouple = 1'b0;

        // timeout: RP accepts nothing
        m_awready = 1'b0; m_wready = 1'b0;
        wq.push_back(2'b10);
        fork
            s_aw(32'h20);
            s_w(32'hFFFF_0000, 4'hC);
        join
        n = 0;
        for (int i = 0; i < 40 && m_awvalid; i++) begin
            n++;
            @(negedge clk);
        end
        chk("to_valid_cycles", n, TO);
        chk("to_wvalid_drop", m_wvalid, 0);
        chk("to_flag", rp_to, 1);
        s_b();
        m_bresp = 2'b00; m_bvalid = 1'b1;
        chk("to_sink_bready", m_bready, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        @(negedge clk);
        chk("to_no_fwd", s_bvalid, 0);
        wq.push_back(2'b10);
        fork
            s_aw(32'h24);
            s_w(32'h5, 4'h1);
        join
        chk("to_local_lat", s_bvalid, 1);
        chk("to_no_issue", m_awvalid, 0);
        chk("to_dec_status", dec_status, 1);
        s_b();
        clear_timeout = 1'b1;
        @(negedge clk);
        clear_timeout = 1'b0;
        chk("to_cleared", rp_to, 0);
        chk("to_status_cleared", dec_status, 0);
        wq.push_back(2'b00);
        fork
            s_aw(32'h28);
            s_w(32'h77, 4'hF);
            rp_write(1, 2'b00, 32'h28, 32'h77, 4'hF);
        join
        s_b();

        // concurrent read and write, W two cycles ahead of AW
        wq.push_back(2'b00);
        rq.push_back({2'b00, 32'hCAFE_F00D});
        fork
            begin
                s_w(32'h0BAD_F00D, 4'h5);
                chk("cc_w_held", s_wready, 0);
            end
            begin
                repeat (2) @(negedge clk);
                s_aw(32'h30);
            end
            s_ar(32'h34);
            rp_write(2, 2'b00, 32'h30, 32'h0BAD_F00D, 4'h5);
            rp_read(1, 32'hCAFE_F00D, 2'b00, 32'h34);
        join
        s_b();
        s_r();

        // reset while the write sits in W_WAIT and a timed-out read is pending
        m_arready = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
        s_ar(32'h40);
        fork
            s_aw(32'h44);
            s_w(32'h9, 4'hF);
        join
        m_awready = 1'b0; m_wready = 1'b0;
        for (int i = 0; i < 40 && !rp_to; i++) @(negedge clk);
        chk("mo_rd_to", rp_to, 1);
        chk("mo_rd_resp", s_rvalid, 1);
        chk("mo_wr_waiting", s_bvalid, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mo_rvalid_async", s_rvalid, 0);
        chk("mo_bready_async", m_bready, 0);
        chk("mo_rp_timeout", rp_to, 0);
        chk("mo_awready_rst", s_awready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mo_awready_rel", s_awready, 1);
        chk("sb_empty", wq.size() + rq.size(), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
